fp_accum_bank: RTL and testbench
================================

FP_ACCUM_BANK -- requirements
Module: fp_accum_bank

Interface
REQ-001 Parameter WIDTH, default 32: operand, accumulator and result width (IEEE-754 single when 32).
REQ-002 Parameter NUM_CH, default 4: number of accumulator channels; power of two, 2..16.
REQ-003 Parameter ADD_LATENCY, default 7: fixed latency in cycles of the external FP adder, 1..31.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 clk_en  input  1  when low, all state (FSM, counters, registers) holds.
REQ-007 start  input  1  one-cycle operation request, sampled only in IDLE.
REQ-008 n  input  2  opcode: 00 ACC, 01 READ, 10 CLEAR, 11 COUNT.
REQ-009 dataa  input  WIDTH  addend for ACC; ignored otherwise.
REQ-010 datab  input  WIDTH  channel select in bits [log2(NUM_CH)-1:0]; upper bits ignored.
REQ-011 result  output  WIDTH  operation result, valid while done high, held until next done.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 add_a, add_b  output  WIDTH  operands to external adder, held stable from issue until capture.
REQ-014 add_en  output  1  equals clk_en; clock enable for external adder pipeline.
REQ-015 add_result  input  WIDTH  adder sum, valid exactly ADD_LATENCY enabled cycles after issue.

Function
REQ-016 FSM states IDLE, ISSUE, WAIT, WRITE, DONE; all transitions require clk_en high.
REQ-017 IDLE: on start, latch n, dataa, channel index; ACC -> ISSUE, READ/CLEAR/COUNT -> DONE.
REQ-018 ISSUE: drive add_a = acc[ch], add_b = latched dataa; load wait counter with ADD_LATENCY-1; -> WAIT.
REQ-019 WAIT: decrement counter; at zero -> WRITE.
REQ-020 WRITE: acc[ch] <= add_result; result <= add_result; -> DONE.
REQ-021 DONE: assert done one cycle; -> IDLE.
REQ-022 ACC latency: done asserted ADD_LATENCY+3 enabled cycles after the start cycle.
REQ-023 READ/CLEAR/COUNT latency: done asserted 2 enabled cycles after the start cycle.
REQ-024 READ: result = acc[ch]; no state change.
REQ-025 CLEAR: result = acc[ch] value before clear; acc[ch] <= 0 in the same cycle the result is loaded.
REQ-026 start outside IDLE is ignored and not queued; no second done.
REQ-027 clk_en low mid-operation stretches latency by the number of disabled cycles; no state lost.
REQ-028 Only the selected channel changes; other channels hold.
REQ-029 FP special values (NaN, Inf, denormals) pass through as the adder produces them; no checks.

Reset
REQ-030 reset overrides clk_en and start; FSM -> IDLE, all acc[] = 0, result = 0, done = 0, add_a = add_b = 0, wait counter = 0.
REQ-031 Reset during WAIT/WRITE aborts the operation: no accumulator update, no done; late add_result is ignored.

Configuration
REQ-032 Macro FP_ACCUM_COUNT_EN defined: per-channel 16-bit accumulation counters, incremented in WRITE, saturating at 0xFFFF, cleared by CLEAR and reset; COUNT returns counter zero-extended to WIDTH.
REQ-033 FP_ACCUM_COUNT_EN undefined: no counters synthesised; COUNT returns 0 with the same 2-cycle latency.

Verification
REQ-034 Reset, READ ch0 -> done after 2 cycles, result 0x00000000.
REQ-035 ACC ch1 dataa 0x461C4000 (10000.0), then ACC ch1 dataa 0x437F0000 (255.0) -> second done after ADD_LATENCY+3 cycles, result 0x46203C00 (10255.0); READ ch0 returns 0.
REQ-036 CLEAR ch1 after REQ-035 -> result 0x46203C00; following READ ch1 -> 0x00000000.
REQ-037 With FP_ACCUM_COUNT_EN: three ACC to ch2, COUNT ch2 -> 0x00000003; without macro -> 0x00000000.
REQ-038 ACC ch3 with start re-pulsed during WAIT and clk_en low 4 cycles -> exactly one done at ADD_LATENCY+7 cycles, one update only.
REQ-039 reset asserted in WAIT of ACC ch0 dataa 0x3F800000 -> no done, READ ch0 returns 0x00000000.

Source files
------------

// File: rtl/fp_accum_bank.sv
// Bank of NUM_CH floating-point accumulators that share one external pipelined adder.
// Optional feature macro FP_ACCUM_COUNT_EN adds saturating per-channel accumulation counters.
module fp_accum_bank #(
  parameter int WIDTH       = 32,
  parameter int NUM_CH      = 4,
  parameter int ADD_LATENCY = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             start,
  input  logic [1:0]       n,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_en,
  input  logic [WIDTH-1:0] add_result
);

  localparam int CH_W = $clog2(NUM_CH);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_DONE} state_t;
  typedef enum logic [1:0] {OP_ACC, OP_READ, OP_CLEAR, OP_COUNT} op_t;

  state_t            state, state_d;
  op_t               op_q;
  logic [CH_W-1:0]   ch_q;
  logic [4:0]        wait_cnt;
  logic [WIDTH-1:0]  acc [NUM_CH];
  logic [WIDTH-1:0]  count_val;
  logic [CH_W-1:0]   ch_sel;
  logic              unused_datab;

  assign ch_sel       = datab[CH_W-1:0];
  assign unused_datab = ^datab[WIDTH-1:CH_W];
  assign add_en       = clk_en;

  // NOTE: combinational process assigns its default first so no path can infer a latch.
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:  if (start) state_d = (op_t'(n) == OP_ACC) ? S_ISSUE : S_DONE;
      S_ISSUE: state_d = (ADD_LATENCY == 1) ? S_WRITE : S_WAIT;
      S_WAIT:  if (wait_cnt <= 5'd1) state_d = S_WRITE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // done is registered from the DONE state, so it appears the cycle after DONE;
  // the adder operands are registered at start, so they are valid during ISSUE.
  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      op_q     <= OP_ACC;
      ch_q     <= '0;
      wait_cnt <= '0;
      result   <= '0;
      done     <= 1'b0;
      add_a    <= '0;
      add_b    <= '0;
      // NOTE: the accumulator array must come up zeroed, so it is reset explicitly here.
      for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
    end else if (clk_en) begin
      state <= state_d;
      done  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            op_q <= op_t'(n);
            ch_q <= ch_sel;
            if (op_t'(n) == OP_ACC) begin
              add_a <= acc[ch_sel];
              add_b <= dataa;
            end
          end
        end
        S_ISSUE: wait_cnt <= 5'(ADD_LATENCY - 1);
        S_WAIT:  wait_cnt <= wait_cnt - 5'd1;
        S_WRITE: begin
          acc[ch_q] <= add_result;
          result    <= add_result;
        end
        S_DONE: begin
          done <= 1'b1;
          unique case (op_q)
            OP_READ:  result <= acc[ch_q];
            OP_CLEAR: begin
              result    <= acc[ch_q];
              acc[ch_q] <= '0;
            end
            OP_COUNT: result <= count_val;
            default:  ;
          endcase
        end
        default: ;
      endcase
    end
  end

`ifdef FP_ACCUM_COUNT_EN
  logic [15:0] acc_cnt [NUM_CH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) acc_cnt[i] <= '0;
    end else if (clk_en) begin
      if (state == S_WRITE && acc_cnt[ch_q] != 16'hFFFF)
        acc_cnt[ch_q] <= acc_cnt[ch_q] + 16'd1;
      else if (state == S_DONE && op_q == OP_CLEAR)
        acc_cnt[ch_q] <= '0;
    end
  end

  assign count_val = WIDTH'(acc_cnt[ch_q]);
`else
  assign count_val = '0;
`endif

endmodule

// File: tb/tb_fp_accum_bank.sv
// Randomised self-checking bench for fp_accum_bank with a behavioural FP adder pipeline
// and a per-channel reference model of the accumulators and counters.
module tb_fp_accum_bank;

  localparam int W  = 32;
  localparam int NC = 4;
  localparam int L  = 7;

  localparam logic [1:0] ACC = 2'b00, READ = 2'b01, CLEAR = 2'b10, COUNT = 2'b11;

  logic          clk = 1'b0;
  logic          reset, clk_en, start;
  logic [1:0]    n;
  logic [W-1:0]  dataa, datab, result, add_a, add_b, add_result;
  logic          done, add_en;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] acc_m [NC];
  int           cnt_m [NC];
  logic [W-1:0] pipe  [L];

  fp_accum_bank #(.WIDTH(W), .NUM_CH(NC), .ADD_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .n(n),
    .dataa(dataa), .datab(datab), .result(result), .done(done),
    .add_a(add_a), .add_b(add_b), .add_en(add_en), .add_result(add_result)
  );

  always #5 clk = ~clk;

  // Single-precision <-> real for normal numbers and zero, via the double format.
  function automatic real sp2real(input logic [31:0] x);
    logic [10:0] e;
    if (x[30:0] == 31'd0) return 0.0;
    e = {3'b000, x[30:23]} + 11'd896;
    return $bitstoreal({x[31], e, x[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] b;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    b = $realtobits(r);
    e = b[62:52] - 11'd896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return real2sp(sp2real(a) + sp2real(b));
  endfunction

  // External adder: an L-stage enabled pipeline.
  always @(posedge clk) begin
    if (add_en) begin
      pipe[0] <= fadd(add_a, add_b);
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign add_result = pipe[L-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      acc_m[i] = '0;
      cnt_m[i] = 0;
    end
  endtask

  // Issue one operation, stalling clk_en for `stall` cycles right after the start cycle.
  task automatic run_op(input logic [1:0] op, input int ch, input logic [31:0] d,
                        input int stall, input string tag);
    logic [31:0] exp;
    int          base, lat;
    lat = -1;
    case (op)
      ACC: begin
        exp = fadd(acc_m[ch], d);
        acc_m[ch] = exp;
        if (cnt_m[ch] < 65535) cnt_m[ch]++;
      end
      READ:  exp = acc_m[ch];
      CLEAR: begin
        exp = acc_m[ch];
        acc_m[ch] = '0;
        cnt_m[ch] = 0;
      end
      default: begin
`ifdef FP_ACCUM_COUNT_EN
        exp = 32'(cnt_m[ch]);
`else
        exp = 32'd0;
`endif
      end
    endcase
    base = (op == ACC) ? L + 3 : 2;

    @(negedge clk);
    start  = 1'b1;
    n      = op;
    dataa  = d;
    datab  = ($urandom() & ~32'(NC - 1)) | 32'(ch);
    clk_en = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start = 1'b0;
      dataa = $urandom();
      if (done) begin
        lat = k;
        break;
      end
      clk_en = (k <= stall) ? 1'b0 : 1'b1;
    end
    clk_en = 1'b1;
    check({tag, "_lat"}, 32'(lat), 32'(base + stall));
    check({tag, "_res"}, result, exp);
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int done_cnt, first_k;
    logic [1:0] op;
    logic [31:0] d;

    reset = 1'b1; clk_en = 1'b1; start = 1'b0; n = READ; dataa = '0; datab = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_done",  {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_add_a",  add_a,  32'd0);
    check("rst_add_b",  add_b,  32'd0);

    run_op(READ, 0, 32'd0, 0, "read0");

    run_op(ACC, 1, 32'h461C4000, 0, "acc1a");
    run_op(ACC, 1, 32'h437F0000, 0, "acc1b");
    check("acc1_const", result, 32'h46203C00);
    run_op(READ, 0, 32'd0, 0, "read0b");

    run_op(CLEAR, 1, 32'd0, 0, "clr1");
    check("clr1_const", result, 32'h46203C00);
    run_op(READ, 1, 32'd0, 0, "read1");
    check("read1_const", result, 32'd0);

    for (int i = 0; i < 3; i++) run_op(ACC, 2, 32'h3F800000, 0, "acc2");
    run_op(COUNT, 2, 32'd0, 0, "cnt2");
`ifdef FP_ACCUM_COUNT_EN
    check("cnt2_const", result, 32'd3);
`else
    check("cnt2_const", result, 32'd0);
`endif

    // ACC ch3 with a re-pulsed start during WAIT and four disabled cycles.
    acc_m[3] = fadd(acc_m[3], 32'h40400000);
    if (cnt_m[3] < 65535) cnt_m[3]++;
    done_cnt = 0; first_k = -1;
    @(negedge clk);
    start = 1'b1; n = ACC; dataa = 32'h40400000; datab = 32'd3;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (first_k < 0) first_k = k;
      end
      start  = (k == 2) ? 1'b1 : 1'b0;
      clk_en = (k >= 3 && k <= 6) ? 1'b0 : 1'b1;
    end
    start = 1'b0; clk_en = 1'b1;
    check("stall_done_cnt", 32'(done_cnt), 32'd1);
    check("stall_done_lat", 32'(first_k), 32'(L + 7));
    check("stall_res", result, acc_m[3]);
    run_op(READ, 3, 32'd0, 0, "read3");

    // Reset asserted while an ACC on ch0 is waiting on the adder.
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1; n = ACC; dataa = 32'h3F800000; datab = 32'd0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
      start = 1'b0;
      reset = (k == 3) ? 1'b1 : 1'b0;
    end
    reset = 1'b0;
    model_reset();
    check("abort_done", 32'(done_cnt), 32'd0);
    check("abort_add_a", add_a, 32'd0);
    run_op(READ, 0, 32'd0, 0, "abort_read0");
    check("abort_read0_const", result, 32'd0);
    run_op(READ, 3, 32'd0, 0, "abort_read3");

    // Random operations, channels, addends and stalls.
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) op = ACC;
      d  = real2sp(real'(int'($urandom_range(0, 4094)) - 2047));
      run_op(op, $urandom_range(0, NC - 1), d, $urandom_range(0, 2), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
